// File: rtl/simple_alu_wb_stage_pkg.sv
// Shared widths, flag bit positions and the skid-buffer entry layout
// for the simple ALU writeback stage.
package simple_alu_wb_stage_pkg;

    localparam int DATA_W  = 32;
    localparam int FLAGS_W = 6;
    localparam int PRF_W   = 7;
    localparam int AL_W    = 7;
    localparam int BMASK_W = 4;

    localparam int FLAG_EXECUTED  = 2;
    localparam int FLAG_EXCEPTION = 1;
    localparam int FLAG_MISPRED   = 0;

    typedef struct packed {
        logic               live;
        logic [DATA_W-1:0]  result;
        logic [FLAGS_W-1:0] flags;
        logic [PRF_W-1:0]   dest;
        logic [AL_W-1:0]    alid;
        logic [BMASK_W-1:0] bmask;
    } wb_entry_t;

    // True when an op's branch mask depends on the resolving branch.
    function automatic logic bmask_hit(input logic [BMASK_W-1:0] bm,
                                       input logic [BMASK_W-1:0] onehot);
        return |(bm & onehot);
    endfunction

endpackage

// File: rtl/simple_alu_wb_stage_wb_skid_fifo.sv
// wb_skid_fifo: 2-entry storage for the ALU writeback stage. Push at tail,
// pop at head, plus per-entry live kill and a branch-mask clear applied
// to every slot.
module wb_skid_fifo
    import simple_alu_wb_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  wb_entry_t            push_entry_i,
    input  logic                 pop_i,
    input  logic [1:0]           kill_i,
    input  logic [BMASK_W-1:0]   clr_bits_i,
    output wb_entry_t            head_o,
    output wb_entry_t [1:0]      entries_o,
    output logic [1:0]           count_o
);

    wb_entry_t [1:0] ent_q, ent_d;
    logic            head_q, head_d;
    logic            tail_q, tail_d;
    logic [1:0]      cnt_q, cnt_d;

    // Next-state: kill/clear all slots, then retire head and fill tail.
    // A pushed slot is always empty, so its write never races a kill.
    always_comb begin
        ent_d  = ent_q;
        head_d = head_q;
        tail_d = tail_q;
        for (int i = 0; i < 2; i++) begin
            if (kill_i[i]) ent_d[i].live = 1'b0;
            ent_d[i].bmask = ent_q[i].bmask & ~clr_bits_i;
        end
        if (pop_i) begin
            ent_d[head_q].live = 1'b0;
            head_d             = ~head_q;
        end
        if (push_i) begin
            ent_d[tail_q] = push_entry_i;
            tail_d        = ~tail_q;
        end
        cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    // State registers; reset wipes storage so data outputs read zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_q  <= '0;
            head_q <= 1'b0;
            tail_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            ent_q  <= ent_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_o    = ent_q[head_q];
    assign entries_o = ent_q;
    assign count_o   = cnt_q;

endmodule

// File: rtl/simple_alu_wb_stage.sv
// simple_alu_wb_stage: captures ALU results into a 2-entry skid buffer and
// presents them to writeback/bypass with valid/ready. Handles branch squash
// and branch-mask clear. Build option SIMPLE_ALU_WB_EARLY_BYPASS_EN moves
// the bypass source from the popping head to the op being pushed.
module simple_alu_wb_stage
    import simple_alu_wb_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DATA_W-1:0]    in_result_i,
    input  logic [FLAGS_W-1:0]   in_flags_i,
    input  logic [PRF_W-1:0]     in_dest_i,
    input  logic [AL_W-1:0]      in_alid_i,
    input  logic [BMASK_W-1:0]   in_bmask_i,
    input  logic                 br_resolve_i,
    input  logic                 br_mispred_i,
    input  logic [BMASK_W-1:0]   br_onehot_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATA_W-1:0]    out_result_o,
    output logic [FLAGS_W-1:0]   out_flags_o,
    output logic [PRF_W-1:0]     out_dest_o,
    output logic [AL_W-1:0]      out_alid_o,
    output logic [BMASK_W-1:0]   out_bmask_o,
    output logic                 out_exception_o,
    output logic                 bypass_valid_o,
    output logic [PRF_W-1:0]     bypass_tag_o,
    output logic [DATA_W-1:0]    bypass_data_o
);

    wb_entry_t          head, push_entry;
    wb_entry_t [1:0]    entries;
    logic [1:0]         count, kill;
    logic [BMASK_W-1:0] clr_bits;
    logic               squash, clear, in_hit, head_hit, push, pop, not_empty;

    assign squash    = br_resolve_i &  br_mispred_i;
    assign clear     = br_resolve_i & ~br_mispred_i;
    assign clr_bits  = clear ? br_onehot_i : '0;
    assign not_empty = (count != 2'd0);

    // Ready depends only on registered count, never on out_ready_i.
    assign in_ready_o = (count != 2'd2);

    // A squashed incoming op is consumed but not stored.
    assign in_hit = squash & bmask_hit(in_bmask_i, br_onehot_i);
    assign push   = in_valid_i & in_ready_o & ~in_hit;

    // Build the entry to store; a same-cycle correct resolve is folded in.
    always_comb begin
        push_entry        = '0;
        push_entry.live   = 1'b1;
        push_entry.result = in_result_i;
        push_entry.flags  = in_flags_i;
        push_entry.dest   = in_dest_i;
        push_entry.alid   = in_alid_i;
        push_entry.bmask  = in_bmask_i & ~clr_bits;
    end

    // Per-slot squash qualification against the resolving branch.
    always_comb begin
        kill = '0;
        for (int i = 0; i < 2; i++)
            kill[i] = squash & bmask_hit(entries[i].bmask, br_onehot_i);
    end

    // Head is hidden in the same cycle it gets squashed; a dead head is
    // retired at the next edge without a handshake.
    assign head_hit    = squash & bmask_hit(head.bmask, br_onehot_i);
    assign out_valid_o = not_empty & head.live & ~head_hit;
    assign pop         = not_empty & ((out_valid_o & out_ready_i) | ~head.live);

    wb_skid_fifo u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .kill_i       (kill),
        .clr_bits_i   (clr_bits),
        .head_o       (head),
        .entries_o    (entries),
        .count_o      (count)
    );

    assign out_result_o    = head.result;
    assign out_flags_o     = head.flags;
    assign out_dest_o      = head.dest;
    assign out_alid_o      = head.alid;
    assign out_bmask_o     = head.bmask;
    assign out_exception_o = head.flags[FLAG_EXCEPTION];

`ifdef SIMPLE_ALU_WB_EARLY_BYPASS_EN
    assign bypass_valid_o = push;
    assign bypass_tag_o   = in_dest_i;
    assign bypass_data_o  = in_result_i;
`else
    assign bypass_valid_o = out_valid_o & out_ready_i;
    assign bypass_tag_o   = head.dest;
    assign bypass_data_o  = head.result;
`endif

endmodule

// File: tb/tb_simple_alu_wb_stage.sv
// Directed bench for simple_alu_wb_stage with an in-order scoreboard.
module tb_simple_alu_wb_stage;
    import simple_alu_wb_stage_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic                in_valid_i, in_ready_o;
    logic [DATA_W-1:0]   in_result_i;
    logic [FLAGS_W-1:0]  in_flags_i;
    logic [PRF_W-1:0]    in_dest_i;
    logic [AL_W-1:0]     in_alid_i;
    logic [BMASK_W-1:0]  in_bmask_i;
    logic                br_resolve_i, br_mispred_i;
    logic [BMASK_W-1:0]  br_onehot_i;
    logic                out_valid_o, out_ready_i;
    logic [DATA_W-1:0]   out_result_o;
    logic [FLAGS_W-1:0]  out_flags_o;
    logic [PRF_W-1:0]    out_dest_o;
    logic [AL_W-1:0]     out_alid_o;
    logic [BMASK_W-1:0]  out_bmask_o;
    logic                out_exception_o;
    logic                bypass_valid_o;
    logic [PRF_W-1:0]    bypass_tag_o;
    logic [DATA_W-1:0]   bypass_data_o;

    simple_alu_wb_stage dut (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_result_i(in_result_i), .in_flags_i(in_flags_i),
        .in_dest_i(in_dest_i), .in_alid_i(in_alid_i), .in_bmask_i(in_bmask_i),
        .br_resolve_i(br_resolve_i), .br_mispred_i(br_mispred_i),
        .br_onehot_i(br_onehot_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_result_o(out_result_o), .out_flags_o(out_flags_o),
        .out_dest_o(out_dest_o), .out_alid_o(out_alid_o),
        .out_bmask_o(out_bmask_o), .out_exception_o(out_exception_o),
        .bypass_valid_o(bypass_valid_o), .bypass_tag_o(bypass_tag_o),
        .bypass_data_o(bypass_data_o)
    );

    typedef struct {
        logic [DATA_W-1:0]  res;
        logic [FLAGS_W-1:0] flg;
        logic [PRF_W-1:0]   dest;
        logic [AL_W-1:0]    alid;
        logic [BMASK_W-1:0] bm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   cur_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one input op; acc says whether the stage is expected to store it.
    task automatic send(input logic v, input logic [31:0] res, input logic [5:0] flg,
                        input logic [6:0] dest, input logic [6:0] alid,
                        input logic [3:0] bm, input bit acc);
        exp_t e;
        in_valid_i  = v;
        in_result_i = res;
        in_flags_i  = flg;
        in_dest_i   = dest;
        in_alid_i   = alid;
        in_bmask_i  = bm;
        cur_acc     = acc;
        if (acc) begin
            e.res = res; e.flg = flg; e.dest = dest; e.alid = alid; e.bm = bm;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        send(1'b0, 32'h0, 6'h0, 7'h0, 7'h0, 4'h0, 1'b0);
    endtask

    task automatic branch(input logic res, input logic mis, input logic [3:0] oh);
        br_resolve_i = res;
        br_mispred_i = mis;
        br_onehot_i  = oh;
    endtask

    // One clock: check any handshake at negedge, update scoreboard for
    // branch events, then advance to just past the rising edge.
    task automatic tick();
        exp_t e;
        exp_t keep[$];
        @(negedge clk);
        if (out_valid_o && out_ready_i) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_out: observed dest %0h expected no output", out_dest_o);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_result", out_result_o, e.res);
                chk("out_flags",  32'(out_flags_o), 32'(e.flg));
                chk("out_dest",   32'(out_dest_o),  32'(e.dest));
                chk("out_alid",   32'(out_alid_o),  32'(e.alid));
                chk("out_bmask",  32'(out_bmask_o), 32'(e.bm));
`ifndef SIMPLE_ALU_WB_EARLY_BYPASS_EN
                chk("bypass_valid", 32'(bypass_valid_o), 32'd1);
                chk("bypass_tag",   32'(bypass_tag_o),   32'(e.dest));
                chk("bypass_data",  bypass_data_o,       e.res);
`endif
            end
        end
`ifdef SIMPLE_ALU_WB_EARLY_BYPASS_EN
        if (cur_acc) begin
            chk("ebyp_valid", 32'(bypass_valid_o), 32'd1);
            chk("ebyp_tag",   32'(bypass_tag_o),   32'(in_dest_i));
            chk("ebyp_data",  bypass_data_o,       in_result_i);
        end
`endif
        if (br_resolve_i && !reset) begin
            foreach (sb[i]) begin
                e = sb[i];
                if (!br_mispred_i) e.bm = e.bm & ~br_onehot_i;
                if (!(br_mispred_i && ((sb[i].bm & br_onehot_i) != 4'h0)))
                    keep.push_back(e);
            end
            sb = keep;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        out_ready_i = 1'b0;
        idle();
        branch(1'b0, 1'b0, 4'h0);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_out_valid",    32'(out_valid_o),    32'd0);
        chk("rst_in_ready",     32'(in_ready_o),     32'd1);
        chk("rst_bypass_valid", 32'(bypass_valid_o), 32'd0);
        chk("rst_out_result",   out_result_o,        32'd0);
        chk("rst_out_dest",     32'(out_dest_o),     32'd0);

        // Basic latency: accept at one edge, presented after it.
        out_ready_i = 1'b1;
        send(1'b1, 32'h0000_00FF, 6'b000110, 7'd5, 7'd1, 4'h0, 1'b1);
        tick();
        idle(); #1;
        chk("lat_out_valid", 32'(out_valid_o),     32'd1);
        chk("lat_result",    out_result_o,         32'hFF);
        chk("lat_dest",      32'(out_dest_o),      32'd5);
        chk("lat_exception", 32'(out_exception_o), 32'd1);
        tick();

        // Backpressure: two fill the buffer, third refused.
        out_ready_i = 1'b0;
        send(1'b1, 32'hA1, 6'h4, 7'd11, 7'd2, 4'h0, 1'b1); tick();
        send(1'b1, 32'hB2, 6'h4, 7'd12, 7'd3, 4'h0, 1'b1); tick();
        chk("full_in_ready", 32'(in_ready_o), 32'd0);
        send(1'b1, 32'hC3, 6'h4, 7'd13, 7'd4, 4'h0, 1'b0); tick();
        idle(); #1;
        chk("full_head_dest", 32'(out_dest_o), 32'd11);
        out_ready_i = 1'b1;
        tick(); tick();
        chk("drain_out_valid", 32'(out_valid_o), 32'd0);
        chk("drain_in_ready",  32'(in_ready_o),  32'd1);

        // Mispredict kills the head; the younger entry follows.
        out_ready_i = 1'b0;
        send(1'b1, 32'hD4, 6'h4, 7'd21, 7'd5, 4'b0010, 1'b1); tick();
        send(1'b1, 32'hE5, 6'h4, 7'd22, 7'd6, 4'b0100, 1'b1); tick();
        idle();
        branch(1'b1, 1'b1, 4'b0010); #1;
        chk("sq_same_cycle_valid", 32'(out_valid_o), 32'd0);
        tick();
        branch(1'b0, 1'b0, 4'h0);
        out_ready_i = 1'b1; #1;
        chk("sq_dead_head_valid", 32'(out_valid_o), 32'd0);
        chk("sq_dead_in_ready",   32'(in_ready_o),  32'd0);
        tick();
        chk("sq_next_valid", 32'(out_valid_o), 32'd1);
        chk("sq_next_dest",  32'(out_dest_o),  32'd22);
        tick();

        // Correct resolve clears the bit from stored and incoming ops.
        out_ready_i = 1'b0;
        send(1'b1, 32'hF6, 6'h4, 7'd31, 7'd7, 4'b0110, 1'b1); tick();
        send(1'b1, 32'h17, 6'h4, 7'd32, 7'd8, 4'b0101, 1'b1);
        branch(1'b1, 1'b0, 4'b0100);
        tick();
        idle();
        branch(1'b0, 1'b0, 4'h0); #1;
        chk("clr_head_bmask", 32'(out_bmask_o), 32'b0010);
        out_ready_i = 1'b1;
        tick(); tick();

        // Incoming op squashed on arrival: consumed, not stored.
        send(1'b1, 32'h28, 6'h4, 7'd40, 7'd9, 4'b0001, 1'b0);
        branch(1'b1, 1'b1, 4'b0001); #1;
        chk("insq_in_ready", 32'(in_ready_o), 32'd1);
        tick();
        idle();
        branch(1'b0, 1'b0, 4'h0); #1;
        chk("insq_out_valid", 32'(out_valid_o), 32'd0);
        chk("insq_in_ready2", 32'(in_ready_o),  32'd1);

        // Back-to-back throughput with out_ready held high.
        for (int k = 0; k < 4; k++) begin
            send(1'b1, 32'h1000 + k, 6'h4, 7'(50 + k), 7'(k), 4'h0, 1'b1);
            tick();
            chk("thru_in_ready", 32'(in_ready_o), 32'd1);
        end
        idle();
        tick(); tick();

        // Reset while full discards everything; inputs ignored meanwhile.
        out_ready_i = 1'b0;
        send(1'b1, 32'h55, 6'h4, 7'd60, 7'd1, 4'h0, 1'b1); tick();
        send(1'b1, 32'h66, 6'h4, 7'd61, 7'd2, 4'h0, 1'b1); tick();
        chk("pre_rst_in_ready", 32'(in_ready_o), 32'd0);
        reset = 1'b1;
        send(1'b1, 32'hDEAD, 6'h4, 7'd62, 7'd3, 4'h0, 1'b0);
        tick();
        reset = 1'b0;
        idle();
        sb.delete();
        #1;
        chk("mrst_out_valid",  32'(out_valid_o),  32'd0);
        chk("mrst_in_ready",   32'(in_ready_o),   32'd1);
        chk("mrst_out_result", out_result_o,      32'd0);

        // Drain anything left, bounded.
        out_ready_i = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
